ddr_tx_sequencer: RTL and testbench
===================================

// Module: ddr_tx_sequencer
//
// PURPOSE
// Serializes a valid/ready stream of WIDTH-bit words into per-cycle bit pairs (d1, d2) for one oddr output lane.
// Inserts a training pattern on request at word boundaries and drives a fixed idle level when no data is queued.
// Sits between the packet/framing logic and the oddr primitive; d1/d2 connect directly to oddr.d1/oddr.d2 on the same clk.
//
// PARAMETERS
// WIDTH       8      word width in bits; even, >= 2; one word = WIDTH/2 clk cycles
// MSB_FIRST   1      1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
// IDLE_VAL    1'b0   level driven on d1 and d2 while idle
// TRAIN_WORD  8'h0F  [WIDTH-1:0] training word, serialized with the same bit order as data
// TRAIN_REPS  4      number of TRAIN_WORD repetitions per training sequence; >= 1
//
// PORTS
// clk         in   1      single clock, shared with the driven oddr
// rst         in   1      synchronous, active-high reset
// s_data      in   WIDTH  input word
// s_valid     in   1      s_data valid
// s_ready     out  1      sequencer accepts s_data this cycle
// train_req   in   1      one-cycle pulse requesting a training sequence
// train_busy  out  1      training pending or in progress
// d1          out  1      first (earlier) bit of the current pair, to oddr.d1
// d2          out  1      second (later) bit of the current pair, to oddr.d2
// word_start  out  1      high on the cycle where d1/d2 carry the first pair of a word (data or training)
// active      out  1      high while d1/d2 carry word bits (not idle)
//
// BEHAVIOUR
// - States: IDLE, DATA, TRAIN.
//   - beat_cnt runs 0..WIDTH/2-1 per word.
//   - rep_cnt runs 0..TRAIN_REPS-1.
// - Reset (rst high at a clk edge):
//   - Next cycle: state=IDLE, d1=d2=IDLE_VAL, word_start=0, active=0, train_busy=0, counters=0.
//   - The training-pending flag is cleared.
//   - s_ready is forced 0 in any cycle where rst=1.
// - d1, d2, word_start and active are registered. s_ready and train_busy are combinational from state, counters and flags.
// - Word boundary is true in IDLE, and on the last beat (beat_cnt=WIDTH/2-1) of a DATA or TRAIN word.
// - s_ready = boundary & ~pending & ~(TRAIN and rep_cnt<TRAIN_REPS-1) & ~rst.
// - Data path:
//   - A transfer (s_valid & s_ready) at edge N loads the shift register.
//   - First pair appears on d1/d2 in cycle N+1, with word_start=1. Latency is 1 cycle.
//   - Pair order:
//     - MSB_FIRST=1: d1=sr[WIDTH-1], d2=sr[WIDTH-2]; then shift left by 2.
//     - MSB_FIRST=0: d1=sr[0], d2=sr[1]; then shift right by 2.
//   - A transfer on the last beat gives back-to-back words with no idle gap.
// - Training:
//   - train_req while train_busy=0 sets pending. train_req while train_busy=1 is ignored.
//   - At the next boundary, pending has priority over s_valid. State goes to TRAIN and pending clears.
//   - TRAIN sends TRAIN_WORD TRAIN_REPS times back to back, with word_start on each repetition.
//   - On the last beat of the last repetition, s_ready may assert (data follows with no gap); otherwise state goes to IDLE.
//   - train_busy = pending | (state==TRAIN).
// - In IDLE with no transfer and no pending request: next cycle d1=d2=IDLE_VAL, active=0.
// - A pending request is never dropped while an in-flight word completes. A word in progress is never truncated except by rst.
// - train_req in the same cycle as a boundary in IDLE: training starts next cycle and s_ready=0 that cycle.
// - rst mid-word: the word is discarded (no partial resume); outputs reach IDLE_VAL next cycle.
//
// TESTING (WIDTH=8, IDLE_VAL=0, TRAIN_WORD=8'h0F, TRAIN_REPS=4)
// 1. rst high 2 cycles -> s_ready=0 during rst; d1=d2=0, active=0 after; s_ready=1 first cycle after rst low.
// 2. MSB_FIRST=1, one word 8'hB4 accepted at N -> (d1,d2)=(1,0),(1,1),(0,1),(0,0) in N+1..N+4; word_start only at N+1; idle at N+5.
// 3. s_valid held with 8'hFF then 8'h00 -> s_ready high only on last beats; 4 cycles (1,1) then 4 cycles (0,0), no gap.
// 4. train_req at beat 1 of 8'hB4, next word queued -> 8'hB4 completes; 16 cycles repeating (0,0),(0,0),(1,1),(1,1); 4 word_start pulses; s_ready=1 on cycle 16; queued word follows immediately.
// 5. rst at beat 2 of a word with train pending -> next cycle d1=d2=0, active=0, train_busy=0; no training after rst release.
// 6. MSB_FIRST=0, word 8'hB4 -> (0,0),(1,0),(1,1),(0,1).

Source files
------------

// File: rtl/ddr_tx_sequencer.sv
// ddr_tx_sequencer: turns a valid/ready word stream into per-cycle (d1, d2)
// bit pairs for one oddr lane. It can insert a training pattern at word
// boundaries and drives IDLE_VAL when nothing is queued.
module ddr_tx_sequencer #(
    parameter int                 WIDTH      = 8,
    parameter bit                 MSB_FIRST  = 1'b1,
    parameter logic               IDLE_VAL   = 1'b0,
    parameter logic [WIDTH-1:0]   TRAIN_WORD = 8'h0F,
    parameter int                 TRAIN_REPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic             train_req,
    output logic             train_busy,
    output logic             d1,
    output logic             d2,
    output logic             word_start,
    output logic             active
);

    localparam int HALF = WIDTH / 2;
    localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int RW   = (TRAIN_REPS > 1) ? $clog2(TRAIN_REPS) : 1;

    typedef enum logic [1:0] {IDLE, DATA, TRAIN} state_t;

    state_t           state, state_nx;
    logic [BW-1:0]    beat_cnt, beat_nx;
    logic [RW-1:0]    rep_cnt, rep_nx;
    logic [WIDTH-1:0] sr, sr_nx;
    logic             pending, pending_nx;
    logic             d1_nx, d2_nx, ws_nx, act_nx;
    logic             boundary, train_more, req_new, pend_eff;

    // Pair that goes on the wire first for a given word.
    function automatic logic [1:0] first_pair(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return {w[WIDTH-1], w[WIDTH-2]};
        else           return {w[0], w[1]};
    endfunction

    // Drop the pair just sent, moving the next pair into the send position.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) return w << 2;
        else           return w >> 2;
    endfunction

    // Handshake and status decode. A fresh train_req counts as pending in the
    // same cycle so a request landing on a boundary blocks the data transfer.
    always_comb begin
        boundary   = (state == IDLE) || (beat_cnt == BW'(HALF - 1));
        train_more = (state == TRAIN) && (rep_cnt < RW'(TRAIN_REPS - 1));
        train_busy = pending || (state == TRAIN);
        req_new    = train_req && !train_busy;
        pend_eff   = pending || req_new;
        s_ready    = boundary && !pend_eff && !train_more && !rst;
    end

    // Next-state, shift register and output pair selection.
    always_comb begin
        state_nx   = state;
        beat_nx    = beat_cnt;
        rep_nx     = rep_cnt;
        sr_nx      = sr;
        pending_nx = pending || req_new;
        d1_nx      = IDLE_VAL;
        d2_nx      = IDLE_VAL;
        ws_nx      = 1'b0;
        act_nx     = 1'b0;
        if (!boundary) begin
            // mid-word: emit the next pair
            beat_nx        = beat_cnt + BW'(1);
            {d1_nx, d2_nx} = first_pair(sr);
            sr_nx          = advance(sr);
            act_nx         = 1'b1;
        end else if (train_more || pend_eff) begin
            // start training or its next repetition
            state_nx       = TRAIN;
            rep_nx         = train_more ? rep_cnt + RW'(1) : '0;
            pending_nx     = train_more ? pending_nx : 1'b0;
            beat_nx        = '0;
            {d1_nx, d2_nx} = first_pair(TRAIN_WORD);
            sr_nx          = advance(TRAIN_WORD);
            ws_nx          = 1'b1;
            act_nx         = 1'b1;
        end else if (s_valid && s_ready) begin
            state_nx       = DATA;
            rep_nx         = '0;
            beat_nx        = '0;
            {d1_nx, d2_nx} = first_pair(s_data);
            sr_nx          = advance(s_data);
            ws_nx          = 1'b1;
            act_nx         = 1'b1;
        end else begin
            state_nx = IDLE;
            rep_nx   = '0;
            beat_nx  = '0;
        end
    end

    // State and output registers; reset discards any word in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            rep_cnt    <= '0;
            sr         <= '0;
            pending    <= 1'b0;
            d1         <= IDLE_VAL;
            d2         <= IDLE_VAL;
            word_start <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_nx;
            beat_cnt   <= beat_nx;
            rep_cnt    <= rep_nx;
            sr         <= sr_nx;
            pending    <= pending_nx;
            d1         <= d1_nx;
            d2         <= d2_nx;
            word_start <= ws_nx;
            active     <= act_nx;
        end
    end

endmodule

// File: tb/tb_ddr_tx_sequencer.sv
// Directed bench for ddr_tx_sequencer: an MSB-first and an LSB-first instance
// share all stimulus; expected output beats are queued as words are offered
// and popped one per clock.
module tb_ddr_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, train_req;
    logic       rdy_m, busy_m, d1_m, d2_m, ws_m, act_m;
    logic       rdy_l, busy_l, d1_l, d2_l, ws_l, act_l;

    typedef struct packed {
        logic [3:0] m;   // {d1, d2, word_start, active} MSB-first instance
        logic [3:0] l;   // same for LSB-first instance
    } beat_t;

    beat_t exp_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    bit    chk_on = 1'b0;

    always #5 clk = ~clk;

    ddr_tx_sequencer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_VAL(1'b0),
                       .TRAIN_WORD(8'h0F), .TRAIN_REPS(4)) dut_m (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_m),
        .train_req(train_req), .train_busy(busy_m), .d1(d1_m), .d2(d2_m),
        .word_start(ws_m), .active(act_m));

    ddr_tx_sequencer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_VAL(1'b0),
                       .TRAIN_WORD(8'h0F), .TRAIN_REPS(4)) dut_l (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(rdy_l),
        .train_req(train_req), .train_busy(busy_l), .d1(d1_l), .d2(d2_l),
        .word_start(ws_l), .active(act_l));

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Queue the first n beats of word w for both bit orders.
    task automatic push_word(input logic [7:0] w, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.m = {w[7-2*i], w[6-2*i], (i == 0), 1'b1};
            b.l = {w[2*i], w[2*i+1], (i == 0), 1'b1};
            exp_q.push_back(b);
        end
    endtask

    // Advance one clock, then compare the registered outputs with the queue
    // head (idle when the queue is empty).
    task automatic tick();
        beat_t e;
        @(posedge clk);
        #1;
        if (chk_on) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk("pair_msb", {d1_m, d2_m, ws_m, act_m}, e.m);
            chk("pair_lsb", {d1_l, d2_l, ws_l, act_l}, e.l);
        end
    endtask

    // Status check of both instances against one expectation.
    task automatic chk_st(input string tag, input logic rdy, input logic busy);
        #1;
        chk({tag, "_msb"}, {2'b00, rdy_m, busy_m}, {2'b00, rdy, busy});
        chk({tag, "_lsb"}, {2'b00, rdy_l, busy_l}, {2'b00, rdy, busy});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; s_data = '0; s_valid = 1'b0; train_req = 1'b0;

        // reset: ready low while rst high, idle outputs afterwards
        tick();
        chk_st("rst_ready", 1'b0, 1'b0);
        chk_on = 1'b1;
        tick();
        chk_st("rst_ready2", 1'b0, 1'b0);
        rst = 1'b0;
        chk_st("post_rst_ready", 1'b1, 1'b0);

        // single word 8'hB4, then idle
        s_data = 8'hB4; s_valid = 1'b1;
        push_word(8'hB4, 4);
        tick();
        s_valid = 1'b0;
        chk_st("b4_beat0", 1'b0, 1'b0);
        tick(); chk_st("b4_beat1", 1'b0, 1'b0);
        tick(); chk_st("b4_beat2", 1'b0, 1'b0);
        tick(); chk_st("b4_beat3", 1'b1, 1'b0);
        tick(); chk_st("b4_idle", 1'b1, 1'b0);

        // back-to-back 8'hFF then 8'h00 with s_valid held
        s_data = 8'hFF; s_valid = 1'b1;
        push_word(8'hFF, 4);
        push_word(8'h00, 4);
        tick();
        s_data = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            chk_st("ff_ready", (i == 3), 1'b0);
        end
        tick();
        s_valid = 1'b0;
        tick(); tick(); tick();
        tick(); chk_st("b2b_idle", 1'b1, 1'b0);

        // training requested mid-word with next word queued behind it
        s_data = 8'hB4; s_valid = 1'b1;
        push_word(8'hB4, 4);
        for (int r = 0; r < 4; r++) push_word(8'h0F, 4);
        push_word(8'h3C, 4);
        tick();
        s_data = 8'h3C;
        tick();                                   // beat 1 on the wire
        train_req = 1'b1;
        tick();
        train_req = 1'b0;
        chk_st("pend_beat2", 1'b0, 1'b1);
        tick(); chk_st("pend_beat3", 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk_st("train_ready", (k == 16), 1'b1);
        end
        tick();                                   // 3C first beat
        s_valid = 1'b0;
        chk_st("after_train", 1'b0, 1'b0);
        tick(); tick(); tick();
        tick(); chk_st("train_idle", 1'b1, 1'b0);

        // train_req on an idle boundary beats a valid word
        s_data = 8'hA5; s_valid = 1'b1; train_req = 1'b1;
        chk_st("req_blocks_ready", 1'b0, 1'b0);
        for (int r = 0; r < 4; r++) push_word(8'h0F, 4);
        push_word(8'hA5, 4);
        tick();
        train_req = 1'b0;
        chk_st("idle_train_busy", 1'b0, 1'b1);
        for (int k = 2; k <= 16; k++) tick();
        chk_st("idle_train_last", 1'b1, 1'b1);
        tick();
        s_valid = 1'b0;
        tick(); tick(); tick(); tick();

        // reset at beat 2 with training pending
        s_data = 8'hB4; s_valid = 1'b1;
        push_word(8'hB4, 3);
        tick();
        s_valid = 1'b0;
        train_req = 1'b1;
        tick();
        train_req = 1'b0;
        chk_st("rst_pend", 1'b0, 1'b1);
        tick();                                   // beat 2
        rst = 1'b1;
        chk_st("rst_mid_ready", 1'b0, 1'b1);
        tick();
        chk_st("rst_mid_busy", 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_st("no_train_after_rst", 1'b1, 1'b0);
        end
        chk("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
